sphere_batch_sequencer: RTL and testbench
=========================================

SPHERE_BATCH_SEQUENCER -- requirements
Module: sphere_batch_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, output buffer depth in entries; legal values 2 or 4.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 start  input  1  batch request; sampled only in IDLE.
REQ-005 abort  input  1  stop batch; sampled in every non-IDLE state.
REQ-006 k_base  input  32  first sequence index of the batch.
REQ-007 count  input  16  number of points in the batch.
REQ-008 base_sel0 / base_sel1  input  2 each  core base selects; latched at start.
REQ-009 core_start  output  1  one-cycle launch pulse to the sphere core.
REQ-010 core_k  output  32  index presented to the core.
REQ-011 core_base_sel0 / core_base_sel1  output  2 each  latched base selects.
REQ-012 core_ready  input  1  core idle and able to accept core_start.
REQ-013 core_done  input  1  one-cycle pulse; core_x/y/z valid in the same cycle.
REQ-014 core_x / core_y / core_z  input  32 each  16.16 point from the core.
REQ-015 out_valid, out_ready  output, input  1 each  output stream handshake.
REQ-016 out_k  output  32  index of the head entry.
REQ-017 out_x / out_y / out_z  output  32 each  head entry coordinates.
REQ-018 out_last  output  1  head entry is the final point of the batch.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 batch_done  output  1  one-cycle end-of-batch pulse.
REQ-021 aborted  output  1  qualifies batch_done; high when the batch ended by abort.

Function
REQ-022 FSM states: IDLE, CHECK, LAUNCH, WAIT_CORE, DRAIN, FINISH.
REQ-023 IDLE: on start=1 latch k_base, count, and base selects. Go to CHECK if count!=0, else go to FINISH.
REQ-024 CHECK: go to LAUNCH only when core_ready=1 and FIFO occupancy < FIFO_DEPTH.
REQ-025 LAUNCH: core_start=1 for exactly this single cycle; next state WAIT_CORE.
REQ-026 core_k holds k_cur stable from LAUNCH through the cycle core_done is seen.
REQ-027 WAIT_CORE on core_done: push {k_cur, core_x, core_y, core_z, last=(remaining==1)} into the FIFO.
REQ-028 After the WAIT_CORE push: if last, go to DRAIN; otherwise k_cur+1, remaining-1, go to CHECK.
REQ-029 k_cur increments modulo 2^32; 0xFFFFFFFF is followed by 0x00000000.
REQ-030 FIFO: first-in first-out. Pop when out_valid && out_ready. out_valid = occupancy != 0. Outputs show the head entry.
REQ-031 FIFO push and pop in the same cycle leave occupancy unchanged and are legal when the FIFO is full.
REQ-032 Output values stay stable while out_valid=1 and out_ready=0.
REQ-033 DRAIN: wait for FIFO empty, then go to FINISH.
REQ-034 FINISH: batch_done=1 for one cycle; next state IDLE.
REQ-035 Abort is latched sticky until FINISH.
REQ-036 Abort in CHECK or DRAIN: flush the FIFO (occupancy=0) and go to FINISH with aborted=1.
REQ-037 Abort in LAUNCH or WAIT_CORE: wait for core_done, discard that result, flush, then FINISH with aborted=1.
REQ-038 start while busy=1 is ignored, with no effect on the batch in progress.
REQ-039 core_start, busy, and batch_done are decoded from the state register only; no combinational path from inputs.
REQ-040 Throughput: at most one core launch in flight at any time.
REQ-041 Latency: start at cycle T gives core_start at T+2 when core_ready=1 and the FIFO is empty.

Reset
REQ-042 When rst_n=0 at a clock edge: state = IDLE, FIFO occupancy = 0, abort latch = 0.
REQ-043 Output values under reset: core_start=0, busy=0, batch_done=0, aborted=0, out_valid=0, out_last=0.
REQ-044 Data outputs under reset: core_k, out_k, out_x, out_y, out_z = 0; core base selects = 0.
REQ-045 Reset mid-batch abandons the batch with no batch_done. A late core_done after reset is ignored in IDLE.

Verification
REQ-046 Bench core model: 6-cycle latency; returns x=k, y=~k, z=k<<1.
REQ-047 Nominal batch: k_base=5, count=3, out_ready=1 -> out_k = 5, 6, 7 in order; out_last only on 7; then one batch_done pulse with aborted=0.
REQ-048 Backpressure: count=5, out_ready=0 until 40 cycles after start. Required: no launch while the FIFO holds FIFO_DEPTH entries; no data lost or reordered; 5 entries delivered after release.
REQ-049 Zero count: start with count=0 -> batch_done at T+1, core_start never asserted, out_valid never asserted.
REQ-050 Wrap: k_base=0xFFFFFFFE, count=3 -> out_k = 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-051 Abort during WAIT_CORE of the 2nd point (count=4): exactly 1 entry output at most, then batch_done with aborted=1, then IDLE. start is ignored throughout the batch.
REQ-052 Reset at mid-batch (rst_n=0 for 1 cycle): all outputs at reset values next cycle. A new batch with k_base=100, count=1 completes normally.

Source files
------------

// File: rtl/sphere_batch_sequencer_if.sv
// Signal bundle joining the batch sequencer to its controller, the sphere core
// and the downstream point consumer.
interface sphere_batch_sequencer_if;
   logic        start;
   logic        abort;
   logic [31:0] k_base;
   logic [15:0] count;
   logic [1:0]  base_sel0;
   logic [1:0]  base_sel1;

   logic        core_start;
   logic [31:0] core_k;
   logic [1:0]  core_base_sel0;
   logic [1:0]  core_base_sel1;
   logic        core_ready;
   logic        core_done;
   logic [31:0] core_x;
   logic [31:0] core_y;
   logic [31:0] core_z;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_k;
   logic [31:0] out_x;
   logic [31:0] out_y;
   logic [31:0] out_z;
   logic        out_last;

   logic        busy;
   logic        batch_done;
   logic        aborted;

   modport master (
      input  start, abort, k_base, count, base_sel0, base_sel1,
             core_ready, core_done, core_x, core_y, core_z, out_ready,
      output core_start, core_k, core_base_sel0, core_base_sel1,
             out_valid, out_k, out_x, out_y, out_z, out_last,
             busy, batch_done, aborted
   );

   modport slave (
      output start, abort, k_base, count, base_sel0, base_sel1,
             core_ready, core_done, core_x, core_y, core_z, out_ready,
      input  core_start, core_k, core_base_sel0, core_base_sel1,
             out_valid, out_k, out_x, out_y, out_z, out_last,
             busy, batch_done, aborted
   );
endinterface

// File: rtl/sphere_batch_sequencer.sv
// Launches one sphere-core evaluation per index of a batch, one at a time, and
// streams the resulting points through a small output FIFO.
module sphere_batch_sequencer #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   sphere_batch_sequencer_if.master bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_LAUNCH, S_WAIT_CORE, S_DRAIN, S_FINISH
   } state_t;

   typedef struct packed {
      logic [31:0] k;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
      logic        last;
   } entry_t;

   state_t      state;
   logic [31:0] k_cur;
   logic [15:0] remaining;
   logic [1:0]  sel0_q;
   logic [1:0]  sel1_q;
   logic        abort_q;

   entry_t           mem [FIFO_DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [OCC_W-1:0] occ;

   logic   out_valid;
   logic   abort_hit;
   logic   push;
   logic   pop;
   logic   flush;
   entry_t head_entry;

   assign out_valid = (occ != '0);
   assign abort_hit = bus.abort | abort_q;
   assign pop       = out_valid & bus.out_ready;
   assign push      = (state == S_WAIT_CORE) & bus.core_done & ~abort_hit;
   // An aborted batch empties the buffer on its way to FINISH, including the
   // case where the discarded in-flight result arrives.
   assign flush     = (((state == S_CHECK) | (state == S_DRAIN)) & abort_hit) |
                      ((state == S_WAIT_CORE) & bus.core_done & abort_hit);

   // NOTE: reset is synchronous, so it lives inside the clocked block as an ordinary branch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         k_cur     <= '0;
         remaining <= '0;
         sel0_q    <= '0;
         sel1_q    <= '0;
         abort_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  k_cur     <= bus.k_base;
                  remaining <= bus.count;
                  sel0_q    <= bus.base_sel0;
                  sel1_q    <= bus.base_sel1;
                  state     <= (bus.count != 16'd0) ? S_CHECK : S_FINISH;
               end
            end
            S_CHECK: begin
               if (abort_hit) begin
                  abort_q <= 1'b1;
                  state   <= S_FINISH;
               end else if (bus.core_ready && (occ < DEPTH_V)) begin
                  state <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               if (bus.abort) abort_q <= 1'b1;
               state <= S_WAIT_CORE;
            end
            S_WAIT_CORE: begin
               if (bus.abort) abort_q <= 1'b1;
               if (bus.core_done) begin
                  if (abort_hit) begin
                     state <= S_FINISH;
                  end else if (remaining == 16'd1) begin
                     state <= S_DRAIN;
                  end else begin
                     k_cur     <= k_cur + 32'd1;
                     remaining <= remaining - 16'd1;
                     state     <= S_CHECK;
                  end
               end
            end
            S_DRAIN: begin
               if (abort_hit) begin
                  abort_q <= 1'b1;
                  state   <= S_FINISH;
               end else if (occ == '0) begin
                  state <= S_FINISH;
               end
            end
            S_FINISH: begin
               abort_q <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         case ({push, pop})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
      end
   end

   // NOTE: the storage array has no reset; every data output is masked by
   // out_valid, so stale words can never reach the pins.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         mem[tail] <= '{k: k_cur, x: bus.core_x, y: bus.core_y, z: bus.core_z,
                        last: (remaining == 16'd1)};
      end
   end

   assign head_entry = mem[head];

   assign bus.core_start     = (state == S_LAUNCH);
   assign bus.busy           = (state != S_IDLE);
   assign bus.batch_done     = (state == S_FINISH);
   assign bus.aborted        = (state == S_FINISH) & abort_q;
   assign bus.core_k         = k_cur;
   assign bus.core_base_sel0 = sel0_q;
   assign bus.core_base_sel1 = sel1_q;

   assign bus.out_valid = out_valid;
   assign bus.out_k     = out_valid ? head_entry.k : 32'd0;
   assign bus.out_x     = out_valid ? head_entry.x : 32'd0;
   assign bus.out_y     = out_valid ? head_entry.y : 32'd0;
   assign bus.out_z     = out_valid ? head_entry.z : 32'd0;
   assign bus.out_last  = out_valid & head_entry.last;
endmodule

// File: tb/tb_sphere_batch_sequencer.sv
// Scoreboard bench: stimulus queues the points each batch should produce, a
// monitor pops and compares them as the output stream delivers entries.
module tb_sphere_batch_sequencer;
   localparam int DEPTH = 2;

   typedef struct packed {
      logic [31:0] k;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
      logic        last;
   } entry_t;

   logic clk;
   logic rst_n;

   sphere_batch_sequencer_if bus ();

   sphere_batch_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int         checks       = 0;
   int         failures     = 0;
   int         launches     = 0;
   int         pops         = 0;
   int         valid_cycles = 0;
   entry_t     exp_q[$];
   bit         exp_done_q[$];
   logic [1:0] exp_sel0     = 2'd0;
   logic [1:0] exp_sel1     = 2'd0;
   bit         ready_rand   = 1'b0;
   logic       ready_force  = 1'b1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference point: the core returns x=k, y=~k, z=k<<1 for index k.
   function automatic entry_t ref_point(input logic [31:0] k, input logic last);
      return '{k: k, x: k, y: ~k, z: k << 1, last: last};
   endfunction

   task automatic expect_points(input logic [31:0] kb, input int cnt);
      for (int i = 0; i < cnt; i++)
         exp_q.push_back(ref_point(kb + 32'(i), i == cnt - 1));
   endtask

   // Call at posedge+1; returns at posedge+1 of the cycle after start was high.
   task automatic drive_start(input logic [31:0] kb, input logic [15:0] cnt);
      logic [1:0] s0;
      logic [1:0] s1;
      s0 = 2'($urandom_range(0, 3));
      s1 = 2'($urandom_range(0, 3));
      exp_sel0      = s0;
      exp_sel1      = s1;
      bus.start     = 1'b1;
      bus.k_base    = kb;
      bus.count     = cnt;
      bus.base_sel0 = s0;
      bus.base_sel1 = s1;
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.k_base    = $urandom;
      bus.count     = 16'($urandom);
      bus.base_sel0 = 2'($urandom_range(0, 3));
      bus.base_sel1 = 2'($urandom_range(0, 3));
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(posedge clk); #1;
         ok = !bus.busy && bus.core_ready && (exp_q.size() == 0) && (exp_done_q.size() == 0);
      end
      check(name, 160'(ok), 160'(1));
      exp_q.delete();
      exp_done_q.delete();
   endtask

   task automatic wait_launches(input string name, input int target, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(posedge clk); #1;
         ok = (launches >= target);
      end
      check(name, 160'(ok), 160'(1));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctrl"}, 160'({bus.core_start, bus.busy, bus.batch_done, bus.aborted,
                                  bus.out_valid, bus.out_last}), 160'(0));
      check({tag, "_core"}, 160'({bus.core_k, bus.core_base_sel0, bus.core_base_sel1}), 160'(0));
      check({tag, "_data"}, 160'({bus.out_k, bus.out_x, bus.out_y, bus.out_z}), 160'(0));
   endtask

   // Output consumer handshake.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk); #2;
         bus.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
      end
   end

   // Sphere core model: 6-cycle latency, busy while computing, random recovery gap.
   initial begin : core_model
      logic [31:0] ck;
      bus.core_ready = 1'b1;
      bus.core_done  = 1'b0;
      bus.core_x     = '0;
      bus.core_y     = '0;
      bus.core_z     = '0;
      forever begin
         @(posedge clk); #1;
         if (bus.core_start) begin
            ck = bus.core_k;
            bus.core_ready = 1'b0;
            check("core_base_sel", 160'({bus.core_base_sel0, bus.core_base_sel1}),
                  160'({exp_sel0, exp_sel1}));
            repeat (6) @(posedge clk);
            #1;
            if (bus.busy) check("core_k_stable", 160'(bus.core_k), 160'(ck));
            bus.core_done = 1'b1;
            bus.core_x    = ck;
            bus.core_y    = ~ck;
            bus.core_z    = ck << 1;
            @(posedge clk); #1;
            bus.core_done = 1'b0;
            bus.core_x    = $urandom;
            bus.core_y    = $urandom;
            bus.core_z    = $urandom;
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
            bus.core_ready = 1'b1;
         end
      end
   end

   // Monitor: samples on the falling edge, pops the scoreboard on each transfer.
   initial begin : monitor
      entry_t cur;
      entry_t held;
      bit     hold_prev;
      bit     launch_pending;
      hold_prev      = 1'b0;
      launch_pending = 1'b0;
      held           = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_prev      = 1'b0;
            launch_pending = 1'b0;
         end else begin
            cur = '{k: bus.out_k, x: bus.out_x, y: bus.out_y, z: bus.out_z, last: bus.out_last};
            if (bus.core_done) launch_pending = 1'b0;
            if (bus.core_start) begin
               launches++;
               check("one_launch_in_flight", 160'(launch_pending), 160'(0));
               launch_pending = 1'b1;
            end
            if (hold_prev) begin
               check("hold_valid", 160'(bus.out_valid), 160'(1));
               check("hold_stable", 160'(cur), 160'(held));
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            held      = cur;
            if (bus.out_valid) valid_cycles++;
            if (bus.out_valid && bus.out_ready) begin
               pops++;
               check("output_expected", 160'(exp_q.size() != 0), 160'(1));
               if (exp_q.size() != 0) check("out_entry", 160'(cur), 160'(exp_q.pop_front()));
            end
            if (bus.batch_done) begin
               check("done_expected", 160'(exp_done_q.size() != 0), 160'(1));
               if (exp_done_q.size() != 0)
                  check("aborted_flag", 160'(bus.aborted), 160'(exp_done_q.pop_front()));
            end
         end
      end
   end

   initial begin : stimulus
      int base;
      int pbase;
      int vbase;
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.k_base    = '0;
      bus.count     = '0;
      bus.base_sel0 = '0;
      bus.base_sel1 = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Nominal batch with launch latency.
      ready_force = 1'b1;
      expect_points(32'd5, 3);
      exp_done_q.push_back(1'b0);
      drive_start(32'd5, 16'd3);
      check("latency_t1_no_launch", 160'(bus.core_start), 160'(0));
      check("busy_after_start", 160'(bus.busy), 160'(1));
      @(posedge clk); #1;
      check("latency_t2_launch", 160'(bus.core_start), 160'(1));
      wait_idle("nominal_idle", 200);

      // Backpressure: consumer stalls for 40 cycles.
      ready_force = 1'b0;
      base = launches;
      expect_points(32'h0000_1000, 5);
      exp_done_q.push_back(1'b0);
      drive_start(32'h0000_1000, 16'd5);
      repeat (39) @(posedge clk);
      #1;
      check("bp_launches_while_full", 160'(launches - base), 160'(DEPTH));
      check("bp_valid_while_stalled", 160'(bus.out_valid), 160'(1));
      ready_force = 1'b1;
      wait_idle("bp_idle", 400);
      check("bp_total_launches", 160'(launches - base), 160'(5));

      // Zero-length batch.
      base  = launches;
      vbase = valid_cycles;
      exp_done_q.push_back(1'b0);
      drive_start($urandom, 16'd0);
      check("zero_done_t1", 160'(bus.batch_done), 160'(1));
      check("zero_not_aborted", 160'(bus.aborted), 160'(0));
      wait_idle("zero_idle", 20);
      check("zero_no_launch", 160'(launches - base), 160'(0));
      check("zero_no_valid", 160'(valid_cycles - vbase), 160'(0));

      // Index wrap.
      expect_points(32'hFFFF_FFFE, 3);
      exp_done_q.push_back(1'b0);
      drive_start(32'hFFFF_FFFE, 16'd3);
      wait_idle("wrap_idle", 200);

      // Abort while the second point is in the core; stray starts meanwhile.
      base  = launches;
      pbase = pops;
      exp_q.push_back(ref_point(32'h0000_2000, 1'b0));
      exp_done_q.push_back(1'b1);
      drive_start(32'h0000_2000, 16'd4);
      for (int i = 0; i < 3; i++) begin
         bus.start     = 1'b1;
         bus.k_base    = 32'hDEAD_0000;
         bus.count     = 16'd9;
         bus.base_sel0 = ~exp_sel0;
         bus.base_sel1 = ~exp_sel1;
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      wait_launches("abort_second_launch", base + 2, 100);
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      wait_idle("abort_idle", 100);
      check("abort_launches", 160'(launches - base), 160'(2));
      check("abort_outputs", 160'(pops - pbase), 160'(1));
      repeat (3) @(posedge clk);
      #1;
      check("abort_stays_idle", 160'(bus.busy), 160'(0));

      // Reset in the middle of a batch, then a fresh batch.
      base = launches;
      expect_points(32'd50, 3);
      drive_start(32'd50, 16'd3);
      wait_launches("reset_first_launch", base + 1, 100);
      @(posedge clk); #1;
      exp_q.delete();
      exp_done_q.delete();
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("mid_reset");
      rst_n = 1'b1;
      wait_idle("post_reset_idle", 50);
      expect_points(32'd100, 1);
      exp_done_q.push_back(1'b0);
      drive_start(32'd100, 16'd1);
      wait_idle("post_reset_batch", 100);

      // Randomized batches with a random consumer.
      ready_rand = 1'b1;
      for (int n = 0; n < 8; n++) begin
         logic [31:0] kb;
         int          cnt;
         kb  = (n % 3 == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 4))) : $urandom;
         cnt = $urandom_range(1, 6);
         expect_points(kb, cnt);
         exp_done_q.push_back(1'b0);
         drive_start(kb, 16'(cnt));
         wait_idle("rand_idle", 500);
      end
      ready_rand = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
